eth_tx_slotbuf: RTL
===================

// Module: eth_tx_slotbuf
// PURPOSE
//  Multi-slot Ethernet TX frame buffer between the AHB-side register/data port and the
//  Manchester serialiser. Software writes payload bytes into the current slot and commits it.
//  The read side streams each committed frame over a valid/ready byte interface:
//  PRE_LEN preamble bytes, SFD, payload, then (optional) FCS. Single clock domain.
// PARAMETERS
//  ADDR_W   8  log2 bytes per slot; max payload per frame = 2**ADDR_W
//  SLOT_W   1  log2 number of frame slots (SLOTS = 2**SLOT_W)
//  PRE_LEN  7  number of 0x55 preamble bytes sent before SFD 0xD5
// PORTS
//  a_clk      in   1         clock, all logic on rising edge
//  rst        in   1         asynchronous active-low reset
//  wr_en      in   1         write wr_data as next payload byte of current write slot
//  wr_data    in   8         payload byte
//  wr_commit  in   1         close current slot as a frame, advance write slot
//  wr_flush   in   1         discard bytes written to current (uncommitted) slot
//  wr_full    out  1         all SLOTS committed and unsent; wr_en/wr_commit ignored
//  wr_err     out  1         one-cycle pulse: dropped write/commit (full, overflow, empty)
//  slot_cnt   out  SLOT_W+1  number of committed, not yet fully sent frames
//  rd_ready   in   1         serialiser accepts rd_data this cycle
//  rd_valid   out  1         rd_data valid
//  rd_data    out  8         current stream byte
//  rd_last    out  1         rd_data is final byte of frame
//  frame_done out  1         one-cycle pulse when final byte accepted (slot freed)
// BEHAVIOUR
//  Interface: reset rst, asynchronous, active-low; clock a_clk.
//  Reset: all outputs 0; slots empty, wr/rd slot pointers 0, byte counts 0, FSM IDLE.
//    Reset mid-frame abandons the frame; no partial byte re-emitted after release.
//  Write side: byte written to mem[wr_slot][wr_cnt], wr_cnt++. wr_cnt==2**ADDR_W -> byte
//    dropped, slot marked ovf, wr_err. Commit: wr_cnt!=0 and !ovf -> len[wr_slot]=wr_cnt,
//    wr_slot++ (wraps mod SLOTS), slot_cnt++, wr_cnt=0. Commit with wr_cnt==0 or ovf ->
//    wr_err, slot contents discarded, wr_slot unchanged.
//  Priority same cycle: wr_flush > (wr_en then wr_commit); wr_en+wr_commit together -> byte
//    included in the committed frame. wr_full -> wr_en/wr_commit ignored, wr_err pulse.
//  Read FSM: IDLE -> PRE (slot_cnt!=0) -> SFD -> DATA -> [FCS] -> IDLE.
//    PRE: 0x55 x PRE_LEN; SFD: 0xD5; DATA: mem[rd_slot][0..len-1]; FCS: 4 bytes.
//    Each state advances only on rd_valid & rd_ready; rd_data/rd_last stable while stalled.
//    rd_valid=1 in every state except IDLE. Commit at cycle N with FSM idle -> rd_valid at N+1.
//  Frame end: last byte accepted -> frame_done pulse, rd_slot++ (wrap), slot_cnt--, FSM IDLE;
//    next frame's PRE starts no earlier than following cycle (one idle cycle between frames).
//  Commit and frame_done same cycle: slot_cnt unchanged, both pointers advance.
//  Memory: SLOTS*2**ADDR_W x 8 array, async read at {rd_slot, rd_idx}.
// CONFIGURATION
//  ETH_TXBUF_CRC_EN defined: FCS state present; CRC-32 IEEE (reflected poly 0xEDB88320,
//    init 0xFFFFFFFF) over DATA bytes as accepted; sent complemented, LSB byte first; rd_last on
//    4th FCS byte. Undefined: no FCS state/logic; rd_last on final DATA byte.
// TESTING
//  Reset then commit frame {AA,BB} -> 55x7, D5, AA, BB(rd_last), frame_done; slot_cnt 1->0.
//  rd_ready held 0 for 5 cycles mid-DATA -> rd_data/rd_last unchanged, no byte skipped.
//  SLOT_W=1: commit 2 frames, rd_ready=0 -> wr_full=1; 3rd wr_en -> wr_err, ignored.
//  Write 2**ADDR_W+1 bytes, commit -> wr_err twice, no frame; wr_flush then commit -> wr_err.
//  CRC_EN: payload ASCII "123456789" -> FCS bytes 26 39 F4 CB, rd_last on CB.
//  Assert rst low mid-DATA -> all outputs 0 next cycle; after release slot_cnt=0, rd_valid=0.

Source files
------------

// File: rtl/eth_tx_slotbuf.sv
// Multi-slot Ethernet TX frame buffer: payload slots in, preamble/SFD/payload[/FCS] byte stream out.
// Define ETH_TXBUF_CRC_EN to append a CRC-32 FCS after each payload.
module eth_tx_slotbuf #(
  parameter int ADDR_W  = 8,
  parameter int SLOT_W  = 1,
  parameter int PRE_LEN = 7
) (
  input  logic            a_clk,
  input  logic            rst,
  input  logic            wr_en_i,
  input  logic [7:0]      wr_data_i,
  input  logic            wr_commit_i,
  input  logic            wr_flush_i,
  output logic            wr_full_o,
  output logic            wr_err_o,
  output logic [SLOT_W:0] slot_cnt_o,
  input  logic            rd_ready_i,
  output logic            rd_valid_o,
  output logic [7:0]      rd_data_o,
  output logic            rd_last_o,
  output logic            frame_done_o
);
  localparam int SLOTS = 2**SLOT_W;
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   PRE_LAST = (ADDR_W+1)'(PRE_LEN - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE = SLOT_W'(1);
  localparam logic [SLOT_W:0]   SC_ONE   = (SLOT_W+1)'(1);
  localparam logic [SLOT_W:0]   SC_FULL  = {1'b1, {SLOT_W{1'b0}}};

  // states: IDLE wait for frame | PRE 0x55 run | SFD 0xD5 | DATA payload | FCS crc bytes
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_SFD  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
`ifdef ETH_TXBUF_CRC_EN
  localparam logic [2:0] S_FCS  = 3'd4;
`endif

  logic [7:0]        mem_q [SLOTS*DEPTH];
  logic [ADDR_W:0]   len_q [SLOTS];
  logic [SLOT_W-1:0] wr_slot_q, wr_slot_d, rd_slot_q, rd_slot_d;
  logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d, idx_q, idx_d, cnt_w;
  logic              ovf_q, ovf_d, wr_err_q, wr_err_d;
  logic [SLOT_W:0]   slot_cnt_q, slot_cnt_d;
  logic [2:0]        state_q, state_d;
  logic              mem_we, commit_ok, accept, last_data, done;
  logic [7:0]        mem_rd;
`ifdef ETH_TXBUF_CRC_EN
  logic [31:0]       crc_q, crc_d, fcs;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign fcs = ~crc_q;
`endif

  assign wr_full_o    = (slot_cnt_q == SC_FULL);
  assign wr_err_o     = wr_err_q;
  assign slot_cnt_o   = slot_cnt_q;
  assign accept       = rd_valid_o & rd_ready_i;
  assign done         = accept & rd_last_o;
  assign frame_done_o = done;
  assign mem_rd       = mem_q[{rd_slot_q, idx_q[ADDR_W-1:0]}];
  assign last_data    = (idx_q == len_q[rd_slot_q] - CNT_ONE);

  // A byte written alongside a commit belongs to the committed frame.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    ovf_d     = ovf_q;
    wr_slot_d = wr_slot_q;
    wr_err_d  = 1'b0;
    mem_we    = 1'b0;
    commit_ok = 1'b0;
    cnt_w     = wr_cnt_q;
    if (wr_flush_i) begin
      wr_cnt_d = '0;
      ovf_d    = 1'b0;
    end else if (wr_full_o) begin
      wr_err_d = wr_en_i | wr_commit_i;
    end else begin
      if (wr_en_i) begin
        if (wr_cnt_q == CNT_MAX) begin
          ovf_d    = 1'b1;
          wr_err_d = 1'b1;
        end else begin
          mem_we = 1'b1;
          cnt_w  = wr_cnt_q + CNT_ONE;
        end
      end
      wr_cnt_d = cnt_w;
      if (wr_commit_i) begin
        if (cnt_w != '0 && !ovf_d) begin
          commit_ok = 1'b1;
          wr_slot_d = wr_slot_q + SLOT_ONE;
        end else begin
          wr_err_d = 1'b1;
        end
        wr_cnt_d = '0;
        ovf_d    = 1'b0;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rd_data_o  = 8'h00;
    rd_last_o  = 1'b0;
    rd_valid_o = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: if (slot_cnt_q != '0 || commit_ok) begin
        state_d = S_PRE;
        idx_d   = '0;
      end
      S_PRE: begin
        rd_data_o = 8'h55;
        if (accept) begin
          if (idx_q == PRE_LAST) state_d = S_SFD;
          else idx_d = idx_q + CNT_ONE;
        end
      end
      S_SFD: begin
        rd_data_o = 8'hD5;
        if (accept) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        rd_data_o = mem_rd;
`ifdef ETH_TXBUF_CRC_EN
        if (accept) begin
          if (last_data) begin
            state_d = S_FCS;
            idx_d   = '0;
          end else idx_d = idx_q + CNT_ONE;
        end
`else
        rd_last_o = last_data;
        if (accept) begin
          if (last_data) state_d = S_IDLE;
          else idx_d = idx_q + CNT_ONE;
        end
`endif
      end
`ifdef ETH_TXBUF_CRC_EN
      S_FCS: begin
        rd_data_o = fcs[{idx_q[1:0], 3'b000} +: 8];
        rd_last_o = (idx_q[1:0] == 2'd3);
        if (accept) begin
          if (idx_q[1:0] == 2'd3) state_d = S_IDLE;
          else idx_d = idx_q + CNT_ONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Simultaneous commit and frame end leave the count unchanged.
  always_comb begin
    slot_cnt_d = slot_cnt_q;
    rd_slot_d  = done ? rd_slot_q + SLOT_ONE : rd_slot_q;
    if (commit_ok && !done) slot_cnt_d = slot_cnt_q + SC_ONE;
    else if (done && !commit_ok) slot_cnt_d = slot_cnt_q - SC_ONE;
  end

  always_ff @(posedge a_clk or negedge rst) begin
    if (!rst) begin
      wr_slot_q  <= '0;
      rd_slot_q  <= '0;
      wr_cnt_q   <= '0;
      idx_q      <= '0;
      ovf_q      <= 1'b0;
      wr_err_q   <= 1'b0;
      slot_cnt_q <= '0;
      state_q    <= S_IDLE;
    end else begin
      wr_slot_q  <= wr_slot_d;
      rd_slot_q  <= rd_slot_d;
      wr_cnt_q   <= wr_cnt_d;
      idx_q      <= idx_d;
      ovf_q      <= ovf_d;
      wr_err_q   <= wr_err_d;
      slot_cnt_q <= slot_cnt_d;
      state_q    <= state_d;
    end
  end

`ifdef ETH_TXBUF_CRC_EN
  always_comb begin
    crc_d = crc_q;
    if (state_q == S_SFD) crc_d = 32'hFFFFFFFF;
    else if (state_q == S_DATA && accept) crc_d = crc_byte(crc_q, rd_data_o);
  end

  always_ff @(posedge a_clk or negedge rst) begin
    if (!rst) crc_q <= 32'hFFFFFFFF;
    else      crc_q <= crc_d;
  end
`endif

  always_ff @(posedge a_clk) begin
    if (mem_we) mem_q[{wr_slot_q, wr_cnt_q[ADDR_W-1:0]}] <= wr_data_i;
    if (commit_ok) len_q[wr_slot_q] <= cnt_w;
  end

endmodule
